// File: rtl/seq_detect_pkg.sv
`default_nettype none
// seq_detect_pkg: default parameters and helpers shared by the seq_detect_param slice.
// Revision 1.0
package seq_detect_pkg;

  localparam int         DEF_WIDTH   = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1101;
  localparam int         DEF_CNT_W   = 8;

  // Width needed to hold a fill level of 0..width inclusive.
  function automatic int fill_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detect_param_sat_counter.sv
`default_nettype none
// sat_counter: synchronous-reset up counter that saturates at all-ones.
// Revision 1.0
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// seq_detect_param: Moore serial pattern detector with fill guard, overlap mode and clock enable.
// Define SEQ_MATCH_CNT_EN to build the saturating match counter. Revision 1.0
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(DEF_PATTERN),
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  input  logic             load,
  input  logic [WIDTH-1:0] pat_in,
  input  logic             overlap,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int             FILL_W    = fill_width(WIDTH);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);

  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [WIDTH-1:0]  pat_q, pat_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              z_q, z_d;
  logic              match_now;

  // Reset contents never count: the history must be fully refilled first.
  assign match_now = (shreg_q == pat_q) && (fill_q == FILL_FULL);

  always_comb begin
    shreg_d = shreg_q;
    pat_d   = pat_q;
    fill_d  = fill_q;
    z_d     = 1'b0;
    if (load) begin
      pat_d   = pat_in;
      shreg_d = '0;
      fill_d  = '0;
    end else if (en) begin
      z_d     = match_now;
      shreg_d = {shreg_q[WIDTH-2:0], in};
      if (match_now && !overlap) begin
        fill_d = FILL_W'(1);
      end else if (fill_q != FILL_FULL) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      pat_q   <= PATTERN;
      fill_q  <= '0;
      z_q     <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      pat_q   <= pat_d;
      fill_q  <= fill_d;
      z_q     <= z_d;
    end
  end

  assign out = shreg_q;
  assign z   = z_q;

`ifdef SEQ_MATCH_CNT_EN
  logic cnt_inc;
  assign cnt_inc = !load && en && match_now;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .q   (match_cnt)
  );
`else
  assign match_cnt = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// tb_seq_detect_param: directed self-checking bench; a second instance uses CNT_W=2 for saturation.
module tb_seq_detect_param;

`ifdef SEQ_MATCH_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       in = 1'b0;
  logic       load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       overlap = 1'b1;
  logic [3:0] out, out2;
  logic       z, z2;
  logic [7:0] cnt;
  logic [1:0] cnt2;

  int n_checks = 0;
  int n_fail = 0;

  seq_detect_param dut (
    .clk(clk), .rst(rst), .en(en), .in(in), .load(load), .pat_in(pat_in),
    .overlap(overlap), .out(out), .z(z), .match_cnt(cnt)
  );

  seq_detect_param #(.WIDTH(4), .PATTERN(4'b1101), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .in(in), .load(load), .pat_in(pat_in),
    .overlap(overlap), .out(out2), .z(z2), .match_cnt(cnt2)
  );

  always #5 clk = ~clk;

  // Drive one edge, then sample 1 time unit after it.
  task automatic edge_drive(input logic e, input logic b);
    en = e;
    in = b;
    @(posedge clk);
    #1;
    en = 1'b0;
    load = 1'b0;
    rst = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    overlap = 1'b1;
    edge_drive(1'b1, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (out !== 4'b0000) begin n_fail++; $display("FAIL reset_out: got %b expected 0000", out); end
    n_checks++;
    if (z !== 1'b0) begin n_fail++; $display("FAIL reset_z: got %b expected 0", z); end
    n_checks++;
    if (cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
  endtask

  task automatic test_basic();
    logic [4:0] s;
    s = 5'b11010;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      edge_drive(1'b1, s[4-i]);
      n_checks++;
      if (z !== (i == 4)) begin n_fail++; $display("FAIL basic_z edge %0d: got %b expected %b", i+1, z, (i == 4)); end
      if (i == 3) begin
        n_checks++;
        if (out !== 4'b1101) begin n_fail++; $display("FAIL basic_out: got %b expected 1101", out); end
      end
    end
    n_checks++;
    if (cnt !== 8'(CNT_ON)) begin n_fail++; $display("FAIL basic_cnt: got %0d expected %0d", cnt, CNT_ON); end
    edge_drive(1'b1, 1'b0);
    n_checks++;
    if (z !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: got %b expected 0", z); end
  endtask

  task automatic test_overlap(input logic ov);
    logic [8:0] s;
    int pulses;
    logic exp_z;
    s = 9'b110110100;
    pulses = 0;
    do_reset();
    overlap = ov;
    for (int i = 0; i < 9; i++) begin
      edge_drive(1'b1, s[8-i]);
      exp_z = (i == 4) || (ov && (i == 7));
      if (z === 1'b1) pulses++;
      n_checks++;
      if (z !== exp_z) begin n_fail++; $display("FAIL overlap%0b_z edge %0d: got %b expected %b", ov, i+1, z, exp_z); end
    end
    n_checks++;
    if (pulses != (ov ? 2 : 1)) begin n_fail++; $display("FAIL overlap%0b_pulses: got %0d expected %0d", ov, pulses, ov ? 2 : 1); end
    n_checks++;
    if (cnt !== 8'(CNT_ON * (ov ? 2 : 1))) begin
      n_fail++; $display("FAIL overlap%0b_cnt: got %0d expected %0d", ov, cnt, CNT_ON * (ov ? 2 : 1));
    end
    overlap = 1'b1;
  endtask

  task automatic test_fill_guard();
    do_reset();
    load = 1'b1;
    pat_in = 4'b0000;
    edge_drive(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      edge_drive(1'b1, 1'b0);
      n_checks++;
      if (z !== (i == 4)) begin n_fail++; $display("FAIL fill_guard_z edge %0d: got %b expected %b", i+1, z, (i == 4)); end
    end
  endtask

  task automatic test_en_gating();
    do_reset();
    edge_drive(1'b1, 1'b1);
    edge_drive(1'b1, 1'b1);
    edge_drive(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      edge_drive(1'b0, 1'b1);
      n_checks++;
      if (out !== 4'b0110) begin n_fail++; $display("FAIL gate_hold_out cycle %0d: got %b expected 0110", i, out); end
    end
    edge_drive(1'b1, 1'b1);
    n_checks++;
    if (z !== 1'b0) begin n_fail++; $display("FAIL gate_z_early: got %b expected 0", z); end
    // Detection edge disabled: history and pending match must survive.
    edge_drive(1'b0, 1'b0);
    n_checks++;
    if (z !== 1'b0 || out !== 4'b1101) begin n_fail++; $display("FAIL gate_wait: got z=%b out=%b expected z=0 out=1101", z, out); end
    edge_drive(1'b1, 1'b0);
    n_checks++;
    if (z !== 1'b1) begin n_fail++; $display("FAIL gate_z: got %b expected 1", z); end
  endtask

  task automatic test_saturation();
    int run;
    logic [1:0] exp_c;
    do_reset();
    load = 1'b1;
    pat_in = 4'b1111;
    edge_drive(1'b0, 1'b0);
    run = 0;
    for (int i = 0; i < 12; i++) begin
      edge_drive(1'b1, (i < 10) ? 1'b1 : 1'b0);
      if (z === 1'b1) run++;
      exp_c = (CNT_ON == 0) ? 2'd0 : ((i < 4) ? 2'd0 : ((i - 3) >= 3 ? 2'd3 : 2'(i - 3)));
      n_checks++;
      if (cnt2 !== exp_c) begin n_fail++; $display("FAIL sat_cnt edge %0d: got %0d expected %0d", i+1, cnt2, exp_c); end
    end
    n_checks++;
    if (run != 7) begin n_fail++; $display("FAIL sat_z_run: got %0d expected 7", run); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] s1;
    logic [4:0] s2;
    s1 = 4'b1101;
    s2 = 5'b10100;
    do_reset();
    for (int i = 0; i < 4; i++) edge_drive(1'b1, s1[3-i]);
    load = 1'b1;
    pat_in = 4'b1010;
    edge_drive(1'b1, 1'b1);
    n_checks++;
    if (z !== 1'b0 || out !== 4'b0000) begin n_fail++; $display("FAIL midload: got z=%b out=%b expected z=0 out=0000", z, out); end
    n_checks++;
    if (cnt !== 8'd0) begin n_fail++; $display("FAIL midload_cnt: got %0d expected 0", cnt); end
    for (int i = 0; i < 5; i++) begin
      edge_drive(1'b1, s2[4-i]);
      n_checks++;
      if (z !== (i == 4)) begin n_fail++; $display("FAIL newpat_z edge %0d: got %b expected %b", i+1, z, (i == 4)); end
    end
    rst = 1'b1;
    load = 1'b1;
    pat_in = 4'b0000;
    edge_drive(1'b1, 1'b1);
    n_checks++;
    if (out !== 4'b0000 || z !== 1'b0 || cnt !== 8'd0) begin
      n_fail++; $display("FAIL rst_prio: got out=%b z=%b cnt=%0d expected 0/0/0", out, z, cnt);
    end
    for (int i = 0; i < 5; i++) begin
      edge_drive(1'b1, s1[3-(i % 4)] & (i < 4));
      n_checks++;
      if (z !== (i == 4)) begin n_fail++; $display("FAIL pat_restored_z edge %0d: got %b expected %b", i+1, z, (i == 4)); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_overlap(1'b1);
    test_overlap(1'b0);
    test_fill_guard();
    test_en_gating();
    test_saturation();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
